alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing the ALU (fixed at 2 in this revision).
REQ-002 Parameter: W, default 32, operand/result width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  [1:0]  requester i presents a command.
REQ-006 req_ready  output  [1:0]  requester i command accepted this cycle when valid&ready.
REQ-007 req_op  input  [1:0][2:0]  per-requester ALUop (010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT).
REQ-008 req_a, req_b  input  [1:0][W-1:0]  per-requester operands.
REQ-009 rsp_valid  output  1  response held valid until taken.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  index of requester that owns the response.
REQ-012 rsp_result  output  W  result.
REQ-013 rsp_status  output  3  {NEGATIVE, OVERFLOW, ZERO} from the ALU.
REQ-014 op_count  output  16  number of completed responses, saturating at 16'hFFFF.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on any accept; EXEC->RESP unconditionally; RESP->IDLE on rsp_valid&rsp_ready, else stay.
REQ-016 req_ready[i] SHALL be 1 only in IDLE and only for the granted requester; at most one bit set per cycle.
REQ-017 Arbitration SHALL be round-robin: pointer selects preferred requester; if only one valid, it is granted; after each accept the pointer moves to the other requester.
REQ-018 On accept, op, A, B and requester id SHALL be registered; requester inputs are ignored until IDLE again.
REQ-019 In EXEC the ALU SHALL be driven from the registered operands; SLT is issued to the ALU as SUB (110).
REQ-020 rsp_result SHALL be the ALU output, except SLT: {31'b0, N^V} of the SUB; rsp_status SHALL be the raw ALU status in all cases.
REQ-021 Unsupported opcodes (011,100,101) SHALL complete normally with result 0 and ALU status passed through; no error flag.
REQ-022 Result, status and id SHALL be registered at end of EXEC; rsp_valid rises the cycle after EXEC (accept at edge T -> rsp_valid from T+2).
REQ-023 rsp_result/rsp_status/rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-024 A new command SHALL NOT be accepted in the cycle the response is taken; earliest next accept is the following cycle (3-cycle minimum throughput).
REQ-025 op_count SHALL increment by 1 on each response handshake, holding at 16'hFFFF.
REQ-026 Arithmetic SHALL wrap modulo 2^W; no flags beyond ALU status.

Reset
REQ-027 On reset: state IDLE, rsp_valid 0, req_ready 0 during reset cycle, rsp_result 0, rsp_status 0, rsp_id 0, op_count 0, RR pointer to requester 0.
REQ-028 Reset asserted in EXEC or RESP SHALL drop the in-flight command with no response produced.

Structure
REQ-029 Package alu_pkg SHALL hold ALUop constants, state enum, status bit indices (NEG=2, OVF=1, ZERO=0).
REQ-030 The existing alu module SHALL be instantiated once as the only sub-module; no second adder for SLT.

Verification
REQ-031 req0 ADD A=5,B=3 alone -> req_ready[0] same cycle, rsp_valid 2 cycles later, result 8, status 000, id 0, op_count 1.
REQ-032 Both valid continuously, req0 AND FF00/0FF0, req1 OR 1/2 -> grants alternate 0,1,0..., results 0F00 and 3 on matching ids.
REQ-033 req1 SLT A=-1,B=1 -> result 1; SLT A=7,B=7 -> result 0, status ZERO=1; SLT A=80000000,B=1 -> result 1 (overflow case).
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid and outputs stable, req_ready=00 throughout, no further accepts.
REQ-035 reset asserted during RESP -> next cycle rsp_valid 0, op_count 0, pointer 0; next req1-only command served normally.
REQ-036 op 011 A=9,B=9 -> result 0, ZERO=1, op_count increments.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and status bit positions.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int ST_NEG  = 2;
    localparam int ST_OVF  = 1;
    localparam int ST_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: single shared adder for ADD/SUB, bitwise AND/OR, zero for unsupported ops.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic [2:0]   status_o
);

    logic         sub;
    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic         ovf_arith;
    logic         ovf;

    always_comb begin
        sub       = (op_i == ALU_SUB);
        b_eff     = sub ? ~b_i : b_i;
        sum       = a_i + b_eff + {{(W-1){1'b0}}, sub};
        // Signed overflow: operands agree in sign but the sum does not.
        ovf_arith = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);

        result_o = '0;
        ovf      = 1'b0;
        case (op_i)
            ALU_ADD, ALU_SUB: begin
                result_o = sum;
                ovf      = ovf_arith;
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase

        status_o          = '0;
        status_o[ST_NEG]  = result_o[W-1];
        status_o[ST_OVF]  = ovf;
        status_o[ST_ZERO] = (result_o == '0);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Two-requester round-robin front end for a single ALU: accept, execute, hold response until taken.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][2:0]     req_op,
    input  logic [NREQ-1:0][W-1:0]   req_a,
    input  logic [NREQ-1:0][W-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [W-1:0]             rsp_result,
    output logic [2:0]               rsp_status,
    output logic [15:0]              op_count
);

    state_t       state_q;
    logic         ptr_q;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         id_q;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_result_q;
    logic [2:0]   rsp_status_q;
    logic [15:0]  count_q;

    logic         gnt_any;
    logic         gnt_id;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_res;
    logic [2:0]   alu_stat;
    logic [W-1:0] result_d;
    logic [15:0]  count_d;

    // Preferred requester wins a tie; a lone requester always wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = ptr_q;
        if (req_valid[ptr_q]) begin
            gnt_any = 1'b1;
            gnt_id  = ptr_q;
        end else if (req_valid[~ptr_q]) begin
            gnt_any = 1'b1;
            gnt_id  = ~ptr_q;
        end
        req_ready = '0;
        if ((state_q == IDLE) && !reset && gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign alu_op = (op_q == ALU_SLT) ? ALU_SUB : op_q;

    alu #(.W(W)) u_alu (
        .op_i     (alu_op),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .status_o (alu_stat)
    );

    // SLT reuses the subtractor: less-than is N xor V of a - b.
    assign result_d = (op_q == ALU_SLT)
                    ? {{(W-1){1'b0}}, alu_stat[ST_NEG] ^ alu_stat[ST_OVF]}
                    : alu_res;
    assign count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q    <= req_op[gnt_id];
                        a_q     <= req_a[gnt_id];
                        b_q     <= req_b[gnt_id];
                        id_q    <= gnt_id;
                        ptr_q   <= ~gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= result_d;
                    rsp_status_q <= alu_stat;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        count_q     <= count_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign op_count   = count_q;

endmodule
